count_seq_ctrl: RTL and testbench
=================================

Name: count_seq_ctrl

Overview:
Sequencing controller for the free-running up-counter datapath. It wraps a WIDTH-bit counter with start/stop/pause control, a programmable terminal count, and one-shot or auto-reload modes. It is the block that drives counting for lab timing and event generation; downstream logic consumes count, busy and the done pulse.

Parameters:
WIDTH, 3, width of the counter and the limit input
PCNT_W, 8, width of the completed-period counter

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  arm and start counting; sampled only in IDLE or DONE
stop  input  1  abort to IDLE; highest priority, any state
pause  input  1  level; while high in RUN/PAUSE, count holds
mode  input  1  0 = one-shot, 1 = auto-reload; latched at start
limit  input  WIDTH  terminal count; latched at start
count  output  WIDTH  current count value (registered)
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle registered pulse at each terminal count
err  output  1  one-cycle registered pulse when start is rejected (limit == 0)
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
periods  output  PCNT_W  completed periods since last start; wraps modulo 2^PCNT_W

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, count=0, busy=0, done=0, err=0, periods=0, latched lim_q=0, mode_q=0. Release takes effect on the next posedge.
- done and err default to 0 every cycle unless set below.
- Priority in every state: stop > pause > start > terminal/increment.
- IDLE: count=0.
  - start=1 and limit!=0: lim_q<=limit, mode_q<=mode, periods<=0, count<=0, go to RUN.
  - start=1 and limit==0: err<=1, stay IDLE.
- RUN:
  - stop: go to IDLE, count<=0.
  - pause: go to PAUSE, count holds with no increment this edge.
  - count!=lim_q: count<=count+1.
  - count==lim_q: done<=1, periods<=periods+1.
    - mode_q=1: count<=0, stay in RUN.
    - mode_q=0: count holds at lim_q, go to DONE.
  - start is ignored; limit and mode changes are ignored until the next start.
- PAUSE:
  - stop: go to IDLE, count<=0.
  - pause=1: hold.
  - pause=0: go to RUN; incrementing resumes on the following edge.
- DONE: count holds lim_q, busy=0.
  - start: re-arm exactly as from IDLE, including the err rule and reload of limit/mode.
  - stop: go to IDLE, count<=0.
- Timing: start sampled at edge k gives RUN with count=0 after k, and count=n after edge k+n.
  - One-shot: done=1 and state=DONE after edge k+L+1.
  - Auto-reload: period is L+1 cycles, with done=1 in the cycle where count returns to 0.
- Arithmetic: count never exceeds lim_q. Maximum lim_q is 2^WIDTH-1, in which case the increment wraps naturally to 0 only in auto-reload mode.
- Stop and pause asserted together: stop wins.
- Start and stop asserted together: stop wins, stays or goes to IDLE.
- Reset asserted mid-RUN: immediate return to reset values; no done pulse.

Test Plan:
- Reset, then start=1 for one cycle with limit=5, mode=0 -> count 0,1,2,3,4,5 over six cycles; done=1 one cycle later; state=3, count held at 5, busy=0, periods=1.
- limit=7, mode=1, run 24 cycles -> count cycles 0..7 repeatedly; done pulses every 8 cycles; periods=3; never enters DONE.
- limit=4, mode=0, pause high for 3 cycles when count=2 -> state=2 and count held at 2 for those 3 cycles; after release count 3,4 then done; total latency start-to-done = 5+3+1 cycles.
- start with limit=0 in IDLE -> err=1 for one cycle, state stays 0, count=0; then start with limit=3 -> normal run.
- Mid-run (count=3, limit=6) drive stop and pause together -> state=0 and count=0 next cycle, no done; likewise drop rst_n asynchronously mid-run -> all outputs 0 immediately.
- In DONE (limit=2), start with limit=6, mode=1 -> RUN with new limit, periods reset to 0, first done after 7 cycles; change limit during RUN -> no effect.

Source files
------------

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequencing controller for a WIDTH-bit up-counter.
// Provides start/stop/pause control, a terminal count latched at start,
// and one-shot or auto-reload operation.
//
// Ports:
//   clk      system clock, all state updates on posedge
//   rst_n    asynchronous active-low reset
//   start    arm and start counting (honoured in IDLE or DONE only)
//   stop     abort to IDLE, highest priority in every state
//   pause    level; holds the count while in RUN/PAUSE
//   mode     0 = one-shot, 1 = auto-reload (latched at start)
//   limit    terminal count (latched at start)
//   count    current count value (registered)
//   busy     high in RUN or PAUSE
//   done     one-cycle pulse at each terminal count
//   err      one-cycle pulse when a start is rejected (limit == 0)
//   state    IDLE=0, RUN=1, PAUSE=2, DONE=3
//   periods  completed periods since last start, wraps modulo 2^PCNT_W
module count_seq_ctrl #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              mode,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        state,
  output logic [PCNT_W-1:0] periods
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    lim_q, lim_d;
  logic                mode_q, mode_d;
  logic [PCNT_W-1:0]   periods_q, periods_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      lim_q     <= '0;
      mode_q    <= 1'b0;
      periods_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      lim_q     <= lim_d;
      mode_q    <= mode_d;
      periods_q <= periods_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lim_d     = lim_q;
    mode_d    = mode_q;
    periods_d = periods_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (stop) begin
          state_d = StIdle;
          count_d = '0;
        end else if (start) begin
          if (limit != '0) begin
            lim_d     = limit;
            mode_d    = mode;
            periods_d = '0;
            count_d   = '0;
            state_d   = StRun;
          end else begin
            // Rejected start leaves the current state (IDLE or DONE) untouched
            err_d = 1'b1;
          end
        end
      end

      StRun: begin
        if (stop) begin
          state_d = StIdle;
          count_d = '0;
        end else if (pause) begin
          state_d = StPause;
        end else if (count_q != lim_q) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          done_d    = 1'b1;
          periods_d = periods_q + PCNT_W'(1);
          if (mode_q) begin
            count_d = '0;
          end else begin
            state_d = StDone;
          end
        end
      end

      StPause: begin
        if (stop) begin
          state_d = StIdle;
          count_d = '0;
        end else if (!pause) begin
          // Resume edge itself does not increment
          state_d = StRun;
        end
      end

      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    count   = count_q;
    busy    = (state_q == StRun) || (state_q == StPause);
    done    = done_q;
    err     = err_q;
    state   = state_q;
    periods = periods_q;
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: the stimulus process pushes the
// hand-computed post-edge expectation for every driven cycle, and a monitor
// pops and compares each one #1 after the rising edge.
module tb_count_seq_ctrl;

  localparam int unsigned WIDTH  = 3;
  localparam int unsigned PCNT_W = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic              clk;
  logic              rst_n;
  logic              start, stop, pause, mode;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  count;
  logic              busy, done, err;
  logic [1:0]        state;
  logic [PCNT_W-1:0] periods;

  typedef struct {
    string             tag;
    logic [1:0]        st;
    logic [WIDTH-1:0]  cnt;
    logic              dn;
    logic              er;
    logic [PCNT_W-1:0] per;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  count_seq_ctrl #(
    .WIDTH  (WIDTH),
    .PCNT_W (PCNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .mode    (mode),
    .limit   (limit),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .state   (state),
    .periods (periods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input string tag, input logic s, input logic sp, input logic p,
                      input logic m, input logic [WIDTH-1:0] lim,
                      input logic [1:0] est, input logic [WIDTH-1:0] ecnt,
                      input logic edn, input logic eer, input logic [PCNT_W-1:0] eper);
    exp_t e;
    start = s;
    stop  = sp;
    pause = p;
    mode  = m;
    limit = lim;
    e.tag = tag;
    e.st  = est;
    e.cnt = ecnt;
    e.dn  = edn;
    e.er  = eer;
    e.per = eper;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic ebusy;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        ebusy = (e.st == RUN) || (e.st == PAUSE);
        n_checks++;
        if (state === e.st && count === e.cnt && done === e.dn && err === e.er &&
            periods === e.per && busy === ebusy) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got st=%0d cnt=%0d done=%0b err=%0b per=%0d busy=%0b, want st=%0d cnt=%0d done=%0b err=%0b per=%0d busy=%0b",
                   e.tag, state, count, done, err, periods, busy,
                   e.st, e.cnt, e.dn, e.er, e.per, ebusy);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; limit = '0;
    #1;
    n_checks++;
    if (state === IDLE && count === '0 && busy === 1'b0 && done === 1'b0 &&
        err === 1'b0 && periods === '0) n_pass++;
    else $display("FAIL reset: got st=%0d cnt=%0d busy=%0b done=%0b err=%0b per=%0d, want all 0",
                  state, count, busy, done, err, periods);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 0, 0, 0, 0, 3'd0, IDLE, 3'd0, 0, 0, 8'd0);

    // One-shot, limit 5
    step("os5_start", 1, 0, 0, 0, 3'd5, RUN, 3'd0, 0, 0, 8'd0);
    for (int i = 1; i <= 5; i++) step("os5_cnt", 0, 0, 0, 0, 3'd5, RUN, 3'(i), 0, 0, 8'd0);
    step("os5_done", 0, 0, 0, 0, 3'd5, DONE, 3'd5, 1, 0, 8'd1);
    step("os5_hold", 0, 0, 0, 0, 3'd5, DONE, 3'd5, 0, 0, 8'd1);

    // Auto-reload, limit 7, from DONE; limit input wiggles mid-run
    step("ar7_start", 1, 0, 0, 1, 3'd7, RUN, 3'd0, 0, 0, 8'd0);
    for (int j = 1; j <= 24; j++)
      step("ar7_cnt", (j == 5), 0, 0, 0, 3'd2, RUN, 3'(j % 8), (j % 8 == 0), 0,
           8'(j / 8));
    step("ar7_stop", 0, 1, 0, 1, 3'd7, IDLE, 3'd0, 0, 0, 8'd3);

    // One-shot with a 3-cycle pause at count 2
    step("ps_start", 1, 0, 0, 0, 3'd4, RUN, 3'd0, 0, 0, 8'd0);
    step("ps_c1", 0, 0, 0, 0, 3'd4, RUN, 3'd1, 0, 0, 8'd0);
    step("ps_c2", 0, 0, 0, 0, 3'd4, RUN, 3'd2, 0, 0, 8'd0);
    for (int i = 0; i < 3; i++) step("ps_hold", 0, 0, 1, 0, 3'd4, PAUSE, 3'd2, 0, 0, 8'd0);
    step("ps_resume", 0, 0, 0, 0, 3'd4, RUN, 3'd2, 0, 0, 8'd0);
    step("ps_c3", 0, 0, 0, 0, 3'd4, RUN, 3'd3, 0, 0, 8'd0);
    step("ps_c4", 0, 0, 0, 0, 3'd4, RUN, 3'd4, 0, 0, 8'd0);
    step("ps_done", 0, 0, 0, 0, 3'd4, DONE, 3'd4, 1, 0, 8'd1);

    // Rejected start, in DONE and in IDLE
    step("err_done", 1, 0, 0, 0, 3'd0, DONE, 3'd4, 0, 1, 8'd1);
    step("stop_done", 0, 1, 0, 0, 3'd0, IDLE, 3'd0, 0, 0, 8'd1);
    step("err_idle", 1, 0, 0, 0, 3'd0, IDLE, 3'd0, 0, 1, 8'd1);
    step("err_clr", 0, 0, 0, 0, 3'd0, IDLE, 3'd0, 0, 0, 8'd1);
    step("l3_start", 1, 0, 0, 0, 3'd3, RUN, 3'd0, 0, 0, 8'd0);
    for (int i = 1; i <= 3; i++) step("l3_cnt", 0, 0, 0, 0, 3'd3, RUN, 3'(i), 0, 0, 8'd0);
    step("l3_done", 0, 0, 0, 0, 3'd3, DONE, 3'd3, 1, 0, 8'd1);
    step("l3_stop", 0, 1, 0, 0, 3'd3, IDLE, 3'd0, 0, 0, 8'd1);

    // Start+stop together in IDLE; then stop+pause mid-run
    step("ss_idle", 1, 1, 0, 0, 3'd6, IDLE, 3'd0, 0, 0, 8'd1);
    step("sp_start", 1, 0, 0, 0, 3'd6, RUN, 3'd0, 0, 0, 8'd0);
    for (int i = 1; i <= 3; i++) step("sp_cnt", 0, 0, 0, 0, 3'd6, RUN, 3'(i), 0, 0, 8'd0);
    step("sp_abort", 0, 1, 1, 0, 3'd6, IDLE, 3'd0, 0, 0, 8'd0);
    step("sp_idle", 0, 0, 0, 0, 3'd6, IDLE, 3'd0, 0, 0, 8'd0);

    // Asynchronous reset mid-run
    step("rs_start", 1, 0, 0, 1, 3'd6, RUN, 3'd0, 0, 0, 8'd0);
    for (int i = 1; i <= 3; i++) step("rs_cnt", 0, 0, 0, 1, 3'd6, RUN, 3'(i), 0, 0, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (state === IDLE && count === '0 && busy === 1'b0 && done === 1'b0 &&
        err === 1'b0 && periods === '0) n_pass++;
    else $display("FAIL async_reset: got st=%0d cnt=%0d busy=%0b done=%0b err=%0b per=%0d, want all 0",
                  state, count, busy, done, err, periods);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("rs_idle", 0, 0, 0, 1, 3'd6, IDLE, 3'd0, 0, 0, 8'd0);

    // DONE at limit 2, re-arm with limit 6 auto-reload; limit changes ignored
    step("l2_start", 1, 0, 0, 0, 3'd2, RUN, 3'd0, 0, 0, 8'd0);
    step("l2_c1", 0, 0, 0, 0, 3'd2, RUN, 3'd1, 0, 0, 8'd0);
    step("l2_c2", 0, 0, 0, 0, 3'd2, RUN, 3'd2, 0, 0, 8'd0);
    step("l2_done", 0, 0, 0, 0, 3'd2, DONE, 3'd2, 1, 0, 8'd1);
    step("re_start", 1, 0, 0, 1, 3'd6, RUN, 3'd0, 0, 0, 8'd0);
    for (int j = 1; j <= 14; j++)
      step("re_cnt", 0, 0, 0, 0, 3'd1, RUN, 3'(j % 7), (j % 7 == 0), 0, 8'(j / 7));
    step("re_stop", 0, 1, 0, 0, 3'd1, IDLE, 3'd0, 0, 0, 8'd2);

    // Maximum limit in one-shot: must stop at 7, not wrap
    step("max_start", 1, 0, 0, 0, 3'd7, RUN, 3'd0, 0, 0, 8'd0);
    for (int i = 1; i <= 7; i++) step("max_cnt", 0, 0, 0, 0, 3'd7, RUN, 3'(i), 0, 0, 8'd0);
    step("max_done", 0, 0, 0, 0, 3'd7, DONE, 3'd7, 1, 0, 8'd1);
    step("max_hold", 0, 0, 0, 0, 3'd7, DONE, 3'd7, 0, 0, 8'd1);

    // Drain the scoreboard (bounded)
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
